// File: rtl/tl_ul_master_bridge.sv
// Single-outstanding load/store to TileLink-UL A/D bridge.
// Optional atomics (LogicalData/ArithmeticData) enabled by defining TLB_ATOMIC_EN.
module tl_ul_master_bridge #(
  parameter int TL_RS     = 4,
  parameter int TL_AW     = 16,
  parameter int SOURCE_ID = 0
) (
  input  logic             tlb_clock_i,
  input  logic             tlb_reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [TL_AW-1:0] req_addr_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_signed_i,
  input  logic [31:0]      req_wdata_i,
`ifdef TLB_ATOMIC_EN
  input  logic             req_amo_i,
  input  logic [2:0]       req_amo_op_i,
`endif
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [2:0]       a_opcode_o,
  output logic [2:0]       a_param_o,
  output logic [3:0]       a_size_o,
  output logic [TL_RS-1:0] a_source_o,
  output logic [TL_AW-1:0] a_address_o,
  output logic [3:0]       a_mask_o,
  output logic [31:0]      a_data_o,
  output logic             a_corrupt_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  input  logic [2:0]       d_opcode_i,
  input  logic [1:0]       d_param_i,
  input  logic [3:0]       d_size_i,
  input  logic [TL_RS-1:0] d_source_i,
  input  logic             d_denied_i,
  input  logic [31:0]      d_data_i,
  input  logic             d_corrupt_i,
  input  logic             d_valid_i,
  output logic             d_ready_o
);
  localparam logic [2:0] OP_PUT = 3'd0, OP_ARITH = 3'd2, OP_LOGIC = 3'd3, OP_GET = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ACMD, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;

  logic [2:0]       r_opcode, r_param;
  logic [1:0]       r_size;
  logic             r_signed, r_err;
  logic [TL_AW-1:0] r_addr;
  logic [31:0]      r_wdata, r_rdata;
  logic [3:0]       r_mask;

  logic       w_req_fire, w_d_fire, w_d_match, w_misalign, w_local_err;
  logic [2:0] w_opcode, w_param;
  logic [3:0] w_mask;
  logic [31:0] w_ext;

  assign w_req_fire = req_valid_i & req_ready_o;
  assign w_d_fire   = d_valid_i & d_ready_o;
  assign w_d_match  = (d_source_i == TL_RS'(SOURCE_ID));
  assign w_misalign = (req_size_i == 2'd3) ||
                      (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00) ||
                      (req_size_i == 2'd1 && req_addr_i[0]);

  always_comb begin
    w_opcode    = req_write_i ? OP_PUT : OP_GET;
    w_param     = 3'd0;
    w_local_err = w_misalign;
`ifdef TLB_ATOMIC_EN
    if (req_amo_i) begin
      if (req_size_i != 2'd2) w_local_err = 1'b1;
      if (req_amo_op_i <= 3'd3) begin
        w_opcode = OP_LOGIC;
        w_param  = req_amo_op_i;
      end else if (req_amo_op_i == 3'd4) begin
        w_opcode = OP_ARITH;
        w_param  = 3'd4;
      end else begin
        w_local_err = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    case (req_size_i)
      2'd0:    w_mask = 4'h1 << req_addr_i[1:0];
      2'd1:    w_mask = req_addr_i[1] ? 4'hC : 4'h3;
      default: w_mask = 4'hF;
    endcase
  end

  // Slave right-aligns read data; extend from the captured access width.
  always_comb begin
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & d_data_i[7]}},  d_data_i[7:0]};
      2'd1:    w_ext = {{16{r_signed & d_data_i[15]}}, d_data_i[15:0]};
      default: w_ext = d_data_i;
    endcase
  end

  always_ff @(posedge tlb_clock_i or negedge tlb_reset_ni) begin
    if (!tlb_reset_ni) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire) w_next = w_local_err ? S_RESP : S_ACMD;
      S_ACMD: if (a_ready_i) w_next = S_WAIT;
      S_WAIT: if (w_d_fire && w_d_match) w_next = S_RESP;
      S_RESP: if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge tlb_clock_i or negedge tlb_reset_ni) begin
    if (!tlb_reset_ni) begin
      r_opcode <= '0; r_param <= '0; r_size <= '0; r_signed <= 1'b0;
      r_addr   <= '0; r_wdata <= '0; r_mask <= '0;
      r_rdata  <= '0; r_err   <= 1'b0;
    end else if (w_req_fire) begin
      r_opcode <= w_opcode; r_param <= w_param; r_size <= req_size_i;
      r_signed <= req_signed_i; r_addr <= req_addr_i; r_wdata <= req_wdata_i;
      r_mask   <= w_mask; r_rdata <= '0; r_err <= w_local_err;
    end else if (w_d_fire && w_d_match) begin
      // Only PutFullData expects a dataless AccessAck.
      r_err   <= d_denied_i | d_corrupt_i |
                 (d_opcode_i != ((r_opcode == OP_PUT) ? 3'd0 : 3'd1));
      r_rdata <= (r_opcode == OP_PUT) ? 32'd0 : w_ext;
    end
  end

  assign req_ready_o = (r_state == S_IDLE) & tlb_reset_ni;
  assign a_valid_o   = (r_state == S_ACMD);
  assign d_ready_o   = (r_state == S_WAIT);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign a_opcode_o  = r_opcode;
  assign a_param_o   = r_param;
  assign a_size_o    = {2'b00, r_size};
  assign a_source_o  = TL_RS'(SOURCE_ID);
  assign a_address_o = r_addr;
  assign a_mask_o    = r_mask;
  assign a_data_o    = r_wdata;
  assign a_corrupt_o = 1'b0;

  logic w_unused;
  assign w_unused = ^{d_param_i, d_size_i};
endmodule

// File: tb/tb_tl_ul_master_bridge.sv
// Directed, table-driven bench for tl_ul_master_bridge plus hand-written corner sequences.
module tb_tl_ul_master_bridge;
  localparam int TL_RS = 4, TL_AW = 16, SOURCE_ID = 0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 0, req_write = 0, req_signed = 0;
  logic [TL_AW-1:0] req_addr = '0;
  logic [1:0] req_size = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0] a_opcode, a_param;
  logic [3:0] a_size, a_mask;
  logic [TL_RS-1:0] a_source;
  logic [TL_AW-1:0] a_address;
  logic [31:0] a_data;
  logic a_corrupt, a_valid, a_ready = 0;
  logic [2:0] d_opcode = '0;
  logic [1:0] d_param = '0;
  logic [3:0] d_size = '0;
  logic [TL_RS-1:0] d_source = '0;
  logic d_denied = 0, d_corrupt = 0, d_valid = 0, d_ready;
  logic [31:0] d_data = '0;
`ifdef TLB_ATOMIC_EN
  logic req_amo = 0;
  logic [2:0] req_amo_op = '0;
`endif

  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  tl_ul_master_bridge #(.TL_RS(TL_RS), .TL_AW(TL_AW), .SOURCE_ID(SOURCE_ID)) dut (
    .tlb_clock_i(clk), .tlb_reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
    .req_wdata_i(req_wdata),
`ifdef TLB_ATOMIC_EN
    .req_amo_i(req_amo), .req_amo_op_i(req_amo_op),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .a_opcode_o(a_opcode), .a_param_o(a_param), .a_size_o(a_size), .a_source_o(a_source),
    .a_address_o(a_address), .a_mask_o(a_mask), .a_data_o(a_data),
    .a_corrupt_o(a_corrupt), .a_valid_o(a_valid), .a_ready_i(a_ready),
    .d_opcode_i(d_opcode), .d_param_i(d_param), .d_size_i(d_size), .d_source_i(d_source),
    .d_denied_i(d_denied), .d_data_i(d_data), .d_corrupt_i(d_corrupt),
    .d_valid_i(d_valid), .d_ready_o(d_ready)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [2:0]  dop;
    logic [31:0] ddata;
    logic        den;
    logic        cor;
    logic        loc;    // expect local error, no A traffic
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    req_valid = 1; req_write = v.wr; req_addr = v.addr; req_size = v.size;
    req_signed = v.sgn; req_wdata = v.wdata;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    if (v.loc) begin
      chk("a_valid_local", {31'd0, a_valid}, 32'd0);
    end else begin
      chk("a_valid", {31'd0, a_valid}, 32'd1);
      chk("a_opcode", {29'd0, a_opcode}, v.wr ? 32'd0 : 32'd4);
      chk("a_param", {29'd0, a_param}, 32'd0);
      chk("a_size", {28'd0, a_size}, {30'd0, v.size});
      chk("a_mask", {28'd0, a_mask}, {28'd0, v.mask});
      chk("a_address", {16'd0, a_address}, {16'd0, v.addr});
      chk("a_data", a_data, v.wdata);
      a_ready = 1;
      @(negedge clk);
      a_ready = 0;
      chk("d_ready", {31'd0, d_ready}, 32'd1);
      d_valid = 1; d_source = SOURCE_ID; d_opcode = v.dop; d_data = v.ddata;
      d_denied = v.den; d_corrupt = v.cor;
      @(negedge clk);
      d_valid = 0; d_denied = 0; d_corrupt = 0;
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
    chk("rsp_rdata", rsp_rdata, v.rdata);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_done", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [TL_AW-1:0] held_addr;
    //        wr addr     sz sg wdata         dop ddata         den cor loc mask  rdata         err
    tv[0]  = '{1, 16'h0010, 2, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0};
    tv[1]  = '{0, 16'h0013, 0, 1, 32'h0,        1, 32'h00000080, 0, 0, 0, 4'h8, 32'hFFFFFF80, 0};
    tv[2]  = '{0, 16'h0013, 0, 0, 32'h0,        1, 32'h00000080, 0, 0, 0, 4'h8, 32'h00000080, 0};
    tv[3]  = '{1, 16'h0011, 1, 0, 32'h1234,     0, 32'h0,        0, 0, 1, 4'h0, 32'h0,        1};
    tv[4]  = '{0, 16'h0012, 1, 1, 32'h0,        1, 32'h12348001, 0, 0, 0, 4'hC, 32'hFFFF8001, 0};
    tv[5]  = '{0, 16'h0000, 1, 0, 32'h0,        1, 32'hFFFF7FFF, 0, 0, 0, 4'h3, 32'h00007FFF, 0};
    tv[6]  = '{0, 16'h0004, 2, 1, 32'h0,        1, 32'hCAFEF00D, 0, 0, 0, 4'hF, 32'hCAFEF00D, 0};
    tv[7]  = '{0, 16'h0006, 2, 0, 32'h0,        0, 32'h0,        0, 0, 1, 4'h0, 32'h0,        1};
    tv[8]  = '{0, 16'h0008, 3, 0, 32'h0,        0, 32'h0,        0, 0, 1, 4'h0, 32'h0,        1};
    tv[9]  = '{0, 16'h0008, 2, 0, 32'h0,        1, 32'h11223344, 1, 0, 0, 4'hF, 32'h11223344, 1};
    tv[10] = '{0, 16'h0009, 0, 0, 32'h0,        1, 32'h000000AB, 0, 1, 0, 4'h2, 32'h000000AB, 1};
    tv[11] = '{0, 16'h000C, 2, 0, 32'h0,        0, 32'h55555555, 0, 0, 0, 4'hF, 32'h55555555, 1};
    tv[12] = '{1, 16'h0002, 1, 0, 32'h0000BEEF, 1, 32'h0,        0, 0, 0, 4'hC, 32'h0,        1};
    tv[13] = '{0, 16'h0001, 0, 1, 32'h0,        1, 32'h0000007F, 0, 0, 0, 4'h2, 32'h0000007F, 0};

    #1;
    chk("reset_outs", {req_ready, a_valid, d_ready, rsp_valid, rsp_err, a_corrupt},  32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_source", {28'd0, a_source}, SOURCE_ID);
    @(negedge clk); rst_n = 1;
    #1 chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

    foreach (tv[i]) run_vec(tv[i]);

    // A stall, wrong-source D drop, response backpressure.
    v = '{0, 16'h0014, 1, 1, 32'h0, 1, 32'h0000F00F, 0, 0, 0, 4'h3, 32'hFFFFF00F, 0};
    issue(v);
    held_addr = a_address;
    for (int i = 0; i < 5; i++) begin
      chk("stall_a_valid", {31'd0, a_valid}, 32'd1);
      chk("stall_a_addr", {16'd0, a_address}, 32'h0014);
      chk("stall_a_mask", {28'd0, a_mask}, 32'h3);
      chk("stall_a_op", {29'd0, a_opcode}, 32'd4);
      @(negedge clk);
    end
    a_ready = 1; @(negedge clk); a_ready = 0;
    d_valid = 1; d_source = SOURCE_ID + 1; d_opcode = 1; d_data = 32'h12345678;
    chk("stray_d_ready", {31'd0, d_ready}, 32'd1);
    @(negedge clk);
    d_valid = 0; d_source = SOURCE_ID;
    chk("stray_dropped", {30'd0, rsp_valid, d_ready}, 32'd1);
    d_valid = 1; d_data = v.ddata;
    @(negedge clk);
    d_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hFFFFF00F);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_addr_unchanged", {16'd0, a_address}, {16'd0, held_addr});
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    chk("bp_done", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted while waiting on D.
    v = '{0, 16'h0018, 2, 0, 32'hA5A5A5A5, 1, 32'h0, 0, 0, 0, 4'hF, 32'h0, 0};
    issue(v);
    a_ready = 1; @(negedge clk); a_ready = 0;
    chk("pre_rst_wait", {31'd0, d_ready}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_ctl", {req_ready, a_valid, d_ready, rsp_valid, rsp_err}, 32'd0);
    chk("rst_addr", {16'd0, a_address}, 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_mask_op", {a_mask, a_opcode}, 32'd0);
    chk("rst_source", {28'd0, a_source}, SOURCE_ID);
    @(negedge clk); rst_n = 1; d_valid = 1; d_opcode = 1;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_d_ready", {31'd0, d_ready}, 32'd0);
    @(negedge clk); d_valid = 0;
    chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

`ifdef TLB_ATOMIC_EN
    req_amo = 1; req_amo_op = 3'd4;
    v = '{1, 16'h0020, 2, 0, 32'd5, 1, 32'd7, 0, 0, 0, 4'hF, 32'd7, 0};
    issue(v);
    chk("amo_a_valid", {31'd0, a_valid}, 32'd1);
    chk("amo_opcode", {29'd0, a_opcode}, 32'd2);
    chk("amo_param", {29'd0, a_param}, 32'd4);
    chk("amo_data", a_data, 32'd5);
    a_ready = 1; @(negedge clk); a_ready = 0;
    d_valid = 1; d_opcode = 1; d_data = 32'd7; d_source = SOURCE_ID;
    @(negedge clk); d_valid = 0;
    chk("amo_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("amo_rdata", rsp_rdata, 32'd7);
    chk("amo_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    req_amo_op = 3'd6;
    issue(v);
    chk("amo_bad_op", {30'd0, a_valid, rsp_err}, 32'd1);
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    req_amo = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
